// File: rtl/jet_pkg.sv
// jet_pkg
// Shared definitions for the Jet Fighter motion controller.
//   - Default keyboard usage codes for the movement and fire keys.
//   - heading_t: 8-way heading code, clockwise from north.
//   - sat_add():    add a step to a velocity and clip it to +/-lim.
//   - heading_of(): map a (dir_x, dir_y) pair to a heading code.
package jet_pkg;

    localparam logic [7:0] KEYCODE_UP    = 8'h1A;
    localparam logic [7:0] KEYCODE_DOWN  = 8'h16;
    localparam logic [7:0] KEYCODE_LEFT  = 8'h04;
    localparam logic [7:0] KEYCODE_RIGHT = 8'h07;
    localparam logic [7:0] KEYCODE_FIRE  = 8'h2C;

    typedef enum logic [2:0] {
        HEAD_N  = 3'd0,
        HEAD_NE = 3'd1,
        HEAD_E  = 3'd2,
        HEAD_SE = 3'd3,
        HEAD_S  = 3'd4,
        HEAD_SW = 3'd5,
        HEAD_W  = 3'd6,
        HEAD_NW = 3'd7
    } heading_t;

    function automatic int sat_add(input int v, input int d, input int lim);
        int s;
        s = v + d;
        if (s > lim) begin
            return lim;
        end
        if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

    // Directions are 2-bit two's complement: 2'b11 = -1, 2'b01 = +1.
    // Screen y grows downward, so dir_y = -1 points north.
    function automatic heading_t heading_of(input logic signed [1:0] dir_x,
                                            input logic signed [1:0] dir_y);
        heading_t h;
        h = HEAD_N;
        case ({dir_x, dir_y})
            4'b0011: h = HEAD_N;
            4'b0111: h = HEAD_NE;
            4'b0100: h = HEAD_E;
            4'b0101: h = HEAD_SE;
            4'b0001: h = HEAD_S;
            4'b1101: h = HEAD_SW;
            4'b1100: h = HEAD_W;
            4'b1111: h = HEAD_NW;
            default: h = HEAD_N;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/jet_axis.sv
// jet_axis
// One motion axis of the jet: velocity with acceleration, friction and a
// speed limit, plus the position register with clamp or wrap at the arena
// edges.
// Ports:
//   frame_clk  frame-rate clock
//   Reset_n    asynchronous active-low reset
//   freeze     holds both registers when high
//   dir        signed direction request (-1, 0, +1)
//   pos        sprite centre on this axis
//   vel        signed velocity on this axis
module jet_axis
    import jet_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int VEL_W     = 4,
    parameter int MIN       = 0,
    parameter int MAX       = 639,
    parameter int SIZE      = 16,
    parameter int START     = 320,
    parameter int ACCEL     = 1,
    parameter int FRICTION  = 1,
    parameter int MAX_SPEED = 3,
    parameter int WRAP_MODE = 0
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic                    freeze,
    input  logic signed [1:0]       dir,
    output logic [COORD_W-1:0]      pos,
    output logic signed [VEL_W-1:0] vel
);

    // Two extra bits let the candidate go negative or past the top
    // without wrapping, so edge tests are plain signed compares.
    localparam int CW = COORD_W + 2;
    localparam logic signed [CW-1:0] LO  = CW'(MIN + SIZE);
    localparam logic signed [CW-1:0] HI  = CW'(MAX - SIZE);
    localparam logic signed [CW-1:0] ONE = CW'(1);

    int                      vi;
    logic signed [VEL_W-1:0] nv;
    logic signed [CW-1:0]    cand;
    logic signed [CW-1:0]    wrapped_hi;
    logic signed [CW-1:0]    wrapped_lo;
    logic [COORD_W-1:0]      next_pos;
    logic signed [VEL_W-1:0] next_vel;

    // New velocity: accelerate toward the held direction, else bleed
    // toward zero without overshooting.
    always_comb begin
        vi = int'(vel);
        nv = vel;
        if (dir != 2'sb00) begin
            nv = VEL_W'(sat_add(vi, int'(dir) * ACCEL, MAX_SPEED));
        end else if (vi > FRICTION) begin
            nv = VEL_W'(vi - FRICTION);
        end else if (vi < -FRICTION) begin
            nv = VEL_W'(vi + FRICTION);
        end else begin
            nv = '0;
        end
    end

    // Position moves by the new velocity in the same frame. Overshoot past
    // an edge either pins the jet and kills its speed, or re-enters from the
    // opposite edge carrying the excess.
    always_comb begin
        cand       = $signed({2'b00, pos}) + CW'(nv);
        wrapped_hi = LO + (cand - HI) - ONE;
        wrapped_lo = HI - (LO - cand) + ONE;
        next_pos   = cand[COORD_W-1:0];
        next_vel   = nv;
        if (cand > HI) begin
            if (WRAP_MODE != 0) begin
                next_pos = wrapped_hi[COORD_W-1:0];
            end else begin
                next_pos = COORD_W'(HI);
                next_vel = '0;
            end
        end else if (cand < LO) begin
            if (WRAP_MODE != 0) begin
                next_pos = wrapped_lo[COORD_W-1:0];
            end else begin
                next_pos = COORD_W'(LO);
                next_vel = '0;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos <= COORD_W'(START);
            vel <= '0;
        end else if (!freeze) begin
            pos <= next_pos;
            vel <= next_vel;
        end
    end

endmodule

// File: rtl/jet_motion.sv
// jet_motion
// Per-player jet controller: decodes the keyboard report, drives the two
// motion axes, tracks the 8-way heading and issues single-frame fire pulses
// separated by a cooldown.
// Ports:
//   frame_clk       frame-rate clock
//   Reset_n         asynchronous active-low reset
//   freeze          pause; all state holds, Fire stays low
//   keycodes        NUM_KEYS keyboard slots, slot k at [8k+7:8k], 0 = empty
//   JetX, JetY      sprite centre
//   JetS            sprite half-size (constant)
//   VelX, VelY      signed velocities
//   Heading         0=N .. 7=NW clockwise
//   Fire            one-frame shot pulse
module jet_motion
    import jet_pkg::*;
#(
    parameter int         COORD_W       = 10,
    parameter int         VEL_W         = 4,
    parameter int         NUM_KEYS      = 6,
    parameter int         X_MIN         = 0,
    parameter int         X_MAX         = 639,
    parameter int         Y_MIN         = 0,
    parameter int         Y_MAX         = 479,
    parameter int         X_START       = 320,
    parameter int         Y_START       = 240,
    parameter int         SIZE          = 16,
    parameter int         ACCEL         = 1,
    parameter int         FRICTION      = 1,
    parameter int         MAX_SPEED     = 3,
    parameter int         WRAP_MODE     = 0,
    parameter int         FIRE_COOLDOWN = 8,
    parameter logic [7:0] KEY_UP        = KEYCODE_UP,
    parameter logic [7:0] KEY_DOWN      = KEYCODE_DOWN,
    parameter logic [7:0] KEY_LEFT      = KEYCODE_LEFT,
    parameter logic [7:0] KEY_RIGHT     = KEYCODE_RIGHT,
    parameter logic [7:0] KEY_FIRE      = KEYCODE_FIRE
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic                    freeze,
    input  logic [NUM_KEYS*8-1:0]   keycodes,
    output logic [COORD_W-1:0]      JetX,
    output logic [COORD_W-1:0]      JetY,
    output logic [COORD_W-1:0]      JetS,
    output logic signed [VEL_W-1:0] VelX,
    output logic signed [VEL_W-1:0] VelY,
    output logic [2:0]              Heading,
    output logic                    Fire
);

    localparam int CD_W = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    logic            up_key, down_key, left_key, right_key, fire_now;
    logic signed [1:0] dir_x, dir_y;
    heading_t        heading_q;
    logic            fire_q, fire_prev;
    logic [CD_W-1:0] cooldown;

    // A key counts as held if it sits in any slot of the report.
    always_comb begin
        up_key    = 1'b0;
        down_key  = 1'b0;
        left_key  = 1'b0;
        right_key = 1'b0;
        fire_now  = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keycodes[8*k +: 8] == KEY_UP)    up_key    = 1'b1;
            if (keycodes[8*k +: 8] == KEY_DOWN)  down_key  = 1'b1;
            if (keycodes[8*k +: 8] == KEY_LEFT)  left_key  = 1'b1;
            if (keycodes[8*k +: 8] == KEY_RIGHT) right_key = 1'b1;
            if (keycodes[8*k +: 8] == KEY_FIRE)  fire_now  = 1'b1;
        end
    end

    // Opposing keys cancel; up is negative y because the screen origin is
    // top-left.
    always_comb begin
        dir_x = 2'sb00;
        dir_y = 2'sb00;
        if (right_key && !left_key) dir_x = 2'sb01;
        else if (left_key && !right_key) dir_x = 2'sb11;
        if (down_key && !up_key) dir_y = 2'sb01;
        else if (up_key && !down_key) dir_y = 2'sb11;
    end

    jet_axis #(
        .COORD_W(COORD_W), .VEL_W(VEL_W), .MIN(X_MIN), .MAX(X_MAX),
        .SIZE(SIZE), .START(X_START), .ACCEL(ACCEL), .FRICTION(FRICTION),
        .MAX_SPEED(MAX_SPEED), .WRAP_MODE(WRAP_MODE)
    ) u_axis_x (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .freeze(freeze),
        .dir(dir_x), .pos(JetX), .vel(VelX)
    );

    jet_axis #(
        .COORD_W(COORD_W), .VEL_W(VEL_W), .MIN(Y_MIN), .MAX(Y_MAX),
        .SIZE(SIZE), .START(Y_START), .ACCEL(ACCEL), .FRICTION(FRICTION),
        .MAX_SPEED(MAX_SPEED), .WRAP_MODE(WRAP_MODE)
    ) u_axis_y (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .freeze(freeze),
        .dir(dir_y), .pos(JetY), .vel(VelY)
    );

    // Heading remembers the last non-idle direction. Fire needs a fresh
    // press (edge on fire_now) and an expired cooldown, so holding the key
    // never repeats a shot. A frozen frame drops any pending pulse.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            heading_q <= HEAD_N;
            fire_q    <= 1'b0;
            fire_prev <= 1'b0;
            cooldown  <= '0;
        end else if (freeze) begin
            fire_q <= 1'b0;
        end else begin
            if ((dir_x != 2'sb00) || (dir_y != 2'sb00)) begin
                heading_q <= heading_of(dir_x, dir_y);
            end
            fire_prev <= fire_now;
            if (fire_now && !fire_prev && (cooldown == '0)) begin
                fire_q   <= 1'b1;
                cooldown <= CD_W'(FIRE_COOLDOWN);
            end else begin
                fire_q <= 1'b0;
                if (cooldown != '0) begin
                    cooldown <= cooldown - 1'b1;
                end
            end
        end
    end

    assign JetS    = COORD_W'(SIZE);
    assign Heading = heading_q;
    assign Fire    = fire_q;

endmodule

// File: tb/tb_jet_motion.sv
// tb_jet_motion
// Drives a clamp-mode and a wrap-mode jet_motion from the same keyboard
// reports. Each frame's expected outputs come from an arithmetic model of
// the game rules and go into a queue; a monitor pops one entry after every
// clock edge and compares it with both DUTs.
module tb_jet_motion;

    localparam int COORD_W       = 10;
    localparam int VEL_W         = 4;
    localparam int NUM_KEYS      = 6;
    localparam int LO_X          = 16;
    localparam int HI_X          = 623;
    localparam int LO_Y          = 16;
    localparam int HI_Y          = 463;
    localparam int ACCEL         = 1;
    localparam int FRICTION      = 1;
    localparam int MAX_SPEED     = 3;
    localparam int FIRE_COOLDOWN = 8;

    logic                    frame_clk = 1'b0;
    logic                    Reset_n   = 1'b0;
    logic                    freeze    = 1'b0;
    logic [NUM_KEYS*8-1:0]   keycodes  = '0;
    logic [COORD_W-1:0]      jet_x_c, jet_y_c, jet_s_c, jet_x_w, jet_y_w, jet_s_w;
    logic signed [VEL_W-1:0] vel_x_c, vel_y_c, vel_x_w, vel_y_w;
    logic [2:0]              heading_c, heading_w;
    logic                    fire_c, fire_w;

    jet_motion #(.WRAP_MODE(0)) dut_clamp (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .freeze(freeze),
        .keycodes(keycodes), .JetX(jet_x_c), .JetY(jet_y_c), .JetS(jet_s_c),
        .VelX(vel_x_c), .VelY(vel_y_c), .Heading(heading_c), .Fire(fire_c)
    );

    jet_motion #(.WRAP_MODE(1)) dut_wrap (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .freeze(freeze),
        .keycodes(keycodes), .JetX(jet_x_w), .JetY(jet_y_w), .JetS(jet_s_w),
        .VelX(vel_x_w), .VelY(vel_y_w), .Heading(heading_w), .Fire(fire_w)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        int xc; int yc; int vxc; int vyc;
        int xw; int yw; int vxw; int vyw;
        int hd; int fire;
    } expect_t;

    expect_t sb[$];
    int checks   = 0;
    int failures = 0;

    // Model state: index 0/1 = clamp x/y, 2/3 = wrap x/y.
    int m_pos[4];
    int m_vel[4];
    int m_heading;
    int m_since;
    bit m_fire_prev;
    int head_table[3][3] = '{'{7, 0, 1}, '{6, 0, 2}, '{5, 4, 3}};

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        m_pos[0] = 320; m_pos[1] = 240; m_pos[2] = 320; m_pos[3] = 240;
        for (int i = 0; i < 4; i++) m_vel[i] = 0;
        m_heading   = 0;
        m_since     = FIRE_COOLDOWN + 1;
        m_fire_prev = 1'b0;
    endfunction

    function automatic void modelAxis(int idx, int dir, int lo, int hi, bit wrap);
        int nv, cand;
        if (dir != 0) begin
            nv = m_vel[idx] + dir * ACCEL;
            if (nv > MAX_SPEED) nv = MAX_SPEED;
            if (nv < -MAX_SPEED) nv = -MAX_SPEED;
        end else if (m_vel[idx] > 0) begin
            nv = (m_vel[idx] > FRICTION) ? m_vel[idx] - FRICTION : 0;
        end else begin
            nv = (m_vel[idx] < -FRICTION) ? m_vel[idx] + FRICTION : 0;
        end
        cand = m_pos[idx] + nv;
        m_vel[idx] = nv;
        if (cand > hi) begin
            if (wrap) m_pos[idx] = lo + (cand - hi - 1);
            else begin m_pos[idx] = hi; m_vel[idx] = 0; end
        end else if (cand < lo) begin
            if (wrap) m_pos[idx] = hi - (lo - cand - 1);
            else begin m_pos[idx] = lo; m_vel[idx] = 0; end
        end else begin
            m_pos[idx] = cand;
        end
    endfunction

    // Requested keys go into random distinct slots; other slots get
    // empty codes or unrelated keys.
    function automatic logic [NUM_KEYS*8-1:0] buildReport(bit up, bit down, bit left, bit right, bit fire);
        logic [NUM_KEYS*8-1:0] r;
        logic [7:0] want[$];
        bit used[NUM_KEYS];
        int s;
        if (up)    want.push_back(8'h1A);
        if (down)  want.push_back(8'h16);
        if (left)  want.push_back(8'h04);
        if (right) want.push_back(8'h07);
        if (fire)  want.push_back(8'h2C);
        for (int k = 0; k < NUM_KEYS; k++) begin
            used[k] = 1'b0;
            r[8*k +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h40 + $urandom_range(0, 31));
        end
        foreach (want[w]) begin
            do s = $urandom_range(0, NUM_KEYS - 1); while (used[s]);
            used[s] = 1'b1;
            r[8*s +: 8] = want[w];
        end
        return r;
    endfunction

    // Called at a falling edge: drives one frame's inputs, predicts the
    // state after the next rising edge, queues it, and returns at the
    // following falling edge.
    task automatic applyStimulus(input bit up, input bit down, input bit left,
                                 input bit right, input bit fire, input bit frz);
        int dx, dy;
        expect_t e;
        keycodes = buildReport(up, down, left, right, fire);
        freeze   = frz;
        dy = (up == down) ? 0 : (up ? -1 : 1);
        dx = (left == right) ? 0 : (right ? 1 : -1);
        e.fire = 0;
        if (!frz) begin
            modelAxis(0, dx, LO_X, HI_X, 1'b0);
            modelAxis(1, dy, LO_Y, HI_Y, 1'b0);
            modelAxis(2, dx, LO_X, HI_X, 1'b1);
            modelAxis(3, dy, LO_Y, HI_Y, 1'b1);
            if (dx != 0 || dy != 0) m_heading = head_table[dy + 1][dx + 1];
            if (m_since < 1000) m_since++;
            if (fire && !m_fire_prev && m_since > FIRE_COOLDOWN) begin
                e.fire  = 1;
                m_since = 0;
            end
            m_fire_prev = fire;
        end
        e.xc = m_pos[0]; e.yc = m_pos[1]; e.vxc = m_vel[0]; e.vyc = m_vel[1];
        e.xw = m_pos[2]; e.yw = m_pos[3]; e.vxw = m_vel[2]; e.vyw = m_vel[3];
        e.hd = m_heading;
        sb.push_back(e);
        @(negedge frame_clk);
    endtask

    // Monitor: one expectation per rising edge while stimulus is active.
    initial begin
        expect_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("jetx_clamp", int'(jet_x_c), e.xc);
                checkOutput("jety_clamp", int'(jet_y_c), e.yc);
                checkOutput("velx_clamp", int'(vel_x_c), e.vxc);
                checkOutput("vely_clamp", int'(vel_y_c), e.vyc);
                checkOutput("jetx_wrap", int'(jet_x_w), e.xw);
                checkOutput("jety_wrap", int'(jet_y_w), e.yw);
                checkOutput("velx_wrap", int'(vel_x_w), e.vxw);
                checkOutput("vely_wrap", int'(vel_y_w), e.vyw);
                checkOutput("heading_clamp", int'(heading_c), e.hd);
                checkOutput("heading_wrap", int'(heading_w), e.hd);
                checkOutput("fire_clamp", int'(fire_c), e.fire);
                checkOutput("fire_wrap", int'(fire_w), e.fire);
            end
        end
    end

    initial begin
        bit fire_seq[12] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        modelReset();
        #12;
        checkOutput("reset_jetx", int'(jet_x_c), 320);
        checkOutput("reset_jety", int'(jet_y_c), 240);
        checkOutput("reset_velx", int'(vel_x_c), 0);
        checkOutput("reset_vely", int'(vel_y_c), 0);
        checkOutput("reset_heading", int'(heading_c), 0);
        checkOutput("reset_fire", int'(fire_c), 0);
        checkOutput("jets_clamp", int'(jet_s_c), 16);
        checkOutput("jets_wrap", int'(jet_s_w), 16);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        repeat (4) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("ramp_jetx", int'(jet_x_c), 329);
        checkOutput("ramp_velx", int'(vel_x_c), 3);
        checkOutput("ramp_heading", int'(heading_c), 2);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("coast_jetx", int'(jet_x_c), 332);
        checkOutput("coast_velx", int'(vel_x_c), 0);

        // Long runs push both jets across the left and right edges.
        repeat (130) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("clamp_low_jetx", int'(jet_x_c), 16);
        repeat (230) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("clamp_high_jetx", int'(jet_x_c), 623);

        // Opposed vertical keys with right held.
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (6) applyStimulus(1, 1, 0, 1, 0, 0);
        checkOutput("cancel_vely", int'(vel_y_c), 0);

        foreach (fire_seq[i]) begin
            applyStimulus(0, 0, 0, 0, fire_seq[i], 0);
            if (i == 9) checkOutput("refire_pulse", int'(fire_c), 1);
        end

        repeat (2) applyStimulus(0, 0, 1, 0, 0, 0);
        repeat (5) applyStimulus(0, 1, 1, 0, 1, 1);
        repeat (3) applyStimulus(0, 1, 1, 0, 1, 0);

        // Asynchronous reset in the middle of a ramp.
        repeat (3) applyStimulus(0, 0, 0, 1, 0, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async_reset_jetx", int'(jet_x_c), 320);
        checkOutput("async_reset_velx", int'(vel_x_c), 0);
        checkOutput("async_reset_jetx_wrap", int'(jet_x_w), 320);
        modelReset();
        @(negedge frame_clk);
        Reset_n = 1'b1;

        for (int blk = 0; blk < 150; blk++) begin
            bit u, d, l, r;
            int len;
            u   = ($urandom_range(0, 2) == 0);
            d   = ($urandom_range(0, 3) == 0);
            l   = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                applyStimulus(u, d, l, r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge frame_clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
